// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and widths for the pipeline controller
package pipe_ctrl_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int INST_ADDR_WIDTH = 32;

  // Instruction loaded into a flushed pipeline register (ADDI x0, x0, 0)
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use comparator (decode sources vs execute load)
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      rs1_re,
  input  logic                      rs2_re,
  input  logic                      ex_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_is_load,
  output logic                      load_use_hit
);

  logic rd_live;
  logic src_match;

  // x0 is hardwired zero, so a load targeting it can never create a dependency
  assign rd_live   = ex_is_load && ex_rd_we && (ex_rd_addr != '0);
  assign src_match = (rs1_re && (rs1_addr == ex_rd_addr)) ||
                     (rs2_re && (rs2_addr == ex_rd_addr));

  assign load_use_hit = id_valid && rd_live && src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard/stall/flush/redirect controller; PIPE_CTRL_PERF_EN adds event counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr_i,
  input  logic                       rs1_re_i,
  input  logic                       rs2_re_i,
  input  logic                       id_fence_i,
  input  logic [INST_ADDR_WIDTH-1:0] id_inst_addr_i,
  input  logic                       ex_rd_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_rd_addr_i,
  input  logic                       ex_is_load_i,
  input  logic                       jump_i,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                       mem_busy_i,
  output logic                       stall_if_o,
  output logic                       stall_id_o,
  output logic                       stall_ex_o,
  output logic                       flush_id_o,
  output logic                       flush_ex_o,
  output logic                       redirect_o,
  output logic [INST_ADDR_WIDTH-1:0] redirect_addr_o,
  output logic                       busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                load_stall_cnt_o,
  output logic [31:0]                flush_cnt_o,
  output logic [31:0]                fence_cnt_o
`endif
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  pipe_state_t                state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [INST_ADDR_WIDTH-1:0] saved_pc_q, saved_pc_d;

  logic load_use_hit;
  logic idle_jump;
  logic idle_fence;
  logic idle_load_stall;

  hazard_detect u_hazard_detect (
    .id_valid     (id_valid_i),
    .rs1_addr     (rs1_addr_i),
    .rs2_addr     (rs2_addr_i),
    .rs1_re       (rs1_re_i),
    .rs2_re       (rs2_re_i),
    .ex_rd_we     (ex_rd_we_i),
    .ex_rd_addr   (ex_rd_addr_i),
    .ex_is_load   (ex_is_load_i),
    .load_use_hit (load_use_hit)
  );

  // IDLE priority: memory wait > jump > fence > load-use
  assign idle_jump       = (state_q == ST_IDLE) && !mem_busy_i && jump_i;
  assign idle_fence      = (state_q == ST_IDLE) && !mem_busy_i && !jump_i && id_fence_i && id_valid_i;
  assign idle_load_stall = (state_q == ST_IDLE) && !mem_busy_i && !jump_i &&
                           !(id_fence_i && id_valid_i) && load_use_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      saved_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    saved_pc_d = saved_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_fence) begin
          state_d    = ST_DRAIN;
          cnt_d      = DRAIN_LOAD;
          saved_pc_d = id_inst_addr_i + 32'd4;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy_i) begin
          if (cnt_q <= 3'd1) begin
            state_d = ST_REDIR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_REDIR: begin
        if (!mem_busy_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_if_o      = 1'b0;
    stall_id_o      = 1'b0;
    stall_ex_o      = 1'b0;
    flush_id_o      = 1'b0;
    flush_ex_o      = 1'b0;
    redirect_o      = 1'b0;
    redirect_addr_o = RESET_PC;
    busy_o          = 1'b0;
    // Reset forces every control low immediately, even mid-drain
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (mem_busy_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            stall_ex_o = 1'b1;
          end else if (idle_jump) begin
            redirect_o      = 1'b1;
            redirect_addr_o = jump_addr_i;
            flush_id_o      = 1'b1;
            flush_ex_o      = 1'b1;
          end else if (idle_fence || idle_load_stall) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
          end
        end
        ST_DRAIN: begin
          stall_if_o      = 1'b1;
          stall_id_o      = 1'b1;
          stall_ex_o      = mem_busy_i;
          flush_ex_o      = 1'b1;
          redirect_addr_o = saved_pc_q;
          busy_o          = 1'b1;
        end
        ST_REDIR: begin
          redirect_o      = 1'b1;
          redirect_addr_o = saved_pc_q;
          stall_ex_o      = mem_busy_i;
          flush_id_o      = 1'b1;
          flush_ex_o      = 1'b1;
          busy_o          = 1'b1;
        end
        default: begin
          busy_o = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_stall_cnt_o <= '0;
      flush_cnt_o      <= '0;
      fence_cnt_o      <= '0;
    end else begin
      if (idle_load_stall) load_stall_cnt_o <= load_stall_cnt_o + 32'd1;
      if (idle_jump)       flush_cnt_o      <= flush_cnt_o + 32'd1;
      if (idle_fence)      fence_cnt_o      <= fence_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with a cycle-level reference model
module tb_pipe_ctrl;

  localparam int          DRAIN = 2;
  localparam logic [31:0] RPC   = 32'h0000_1000;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        re1;
    logic        re2;
    logic        fence;
    logic [31:0] iaddr;
    logic        we;
    logic [4:0]  rd;
    logic        ld;
    logic        jmp;
    logic [31:0] jaddr;
    logic        mb;
  } stim_t;

  typedef struct {
    logic [6:0]  flags;
    logic [31:0] addr;
    bit          chk_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, rs1_re, rs2_re, id_fence, ex_rd_we, ex_is_load, jump, mem_busy;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd_addr;
  logic [31:0] id_inst_addr, jump_addr, redirect_addr;
  logic stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect, busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] load_stall_cnt, flush_cnt, fence_cnt;
`endif

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_re_i(rs1_re), .rs2_re_i(rs2_re), .id_fence_i(id_fence),
    .id_inst_addr_i(id_inst_addr), .ex_rd_we_i(ex_rd_we), .ex_rd_addr_i(ex_rd_addr),
    .ex_is_load_i(ex_is_load), .jump_i(jump), .jump_addr_i(jump_addr),
    .mem_busy_i(mem_busy),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex), .redirect_o(redirect),
    .redirect_addr_o(redirect_addr), .busy_o(busy)
`ifdef PIPE_CTRL_PERF_EN
    , .load_stall_cnt_o(load_stall_cnt), .flush_cnt_o(flush_cnt), .fence_cnt_o(fence_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // Reference model: cycles of fence drain remaining, and a pending fence redirect
  int          m_drain_left;
  bit          m_redir;
  logic [31:0] m_saved;
  int          m_loads, m_jumps, m_fences;

  function automatic stim_t quiet();
    stim_t t;
    t = '{v:1'b0, rs1:5'd0, rs2:5'd0, re1:1'b0, re2:1'b0, fence:1'b0, iaddr:32'd0,
          we:1'b0, rd:5'd0, ld:1'b0, jmp:1'b0, jaddr:32'd0, mb:1'b0};
    return t;
  endfunction

  task automatic model_reset();
    m_drain_left = 0;
    m_redir      = 1'b0;
    m_saved      = RPC;
    m_loads      = 0;
    m_jumps      = 0;
    m_fences     = 0;
  endtask

  task automatic step(input stim_t t);
    exp_t e;
    bit   hit;
    @(posedge clk);
    #1;
    rst = 1'b1;
    id_valid = t.v; rs1_addr = t.rs1; rs2_addr = t.rs2; rs1_re = t.re1; rs2_re = t.re2;
    id_fence = t.fence; id_inst_addr = t.iaddr; ex_rd_we = t.we; ex_rd_addr = t.rd;
    ex_is_load = t.ld; jump = t.jmp; jump_addr = t.jaddr; mem_busy = t.mb;
    hit = t.v && t.ld && t.we && (t.rd != 0) &&
          ((t.re1 && t.rs1 == t.rd) || (t.re2 && t.rs2 == t.rd));
    // flags: {stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect, busy}
    e.flags = 7'b0; e.addr = RPC; e.chk_addr = 1'b0;
    if (m_redir) begin
      e.flags = {2'b00, t.mb, 4'b1111};
      e.addr = m_saved; e.chk_addr = 1'b1;
      if (!t.mb) m_redir = 1'b0;
    end else if (m_drain_left > 0) begin
      e.flags = {2'b11, t.mb, 4'b0101};
      if (!t.mb) begin
        if (m_drain_left == 1) m_redir = 1'b1;
        m_drain_left--;
      end
    end else begin
      e.chk_addr = 1'b1;
      if (t.mb) e.flags = 7'b1110000;
      else if (t.jmp) begin
        e.flags = 7'b0001110; e.addr = t.jaddr; m_jumps++;
      end else if (t.fence && t.v) begin
        e.flags = 7'b1100100; m_saved = t.iaddr + 32'd4; m_drain_left = DRAIN; m_fences++;
      end else if (hit) begin
        e.flags = 7'b1100100; m_loads++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic reset_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    mem_busy = 1'b1; jump = 1'b1; jump_addr = 32'hDEAD_BEE0;
    rst = 1'b0;
    #1;
    total++;
    if ({stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect, busy} != 7'b0 ||
        redirect_addr != RPC) begin
      bad++;
      $display("FAIL async_reset: flags=%b addr=%h required flags=0 addr=%h",
               {stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect, busy}, redirect_addr, RPC);
    end
    e.flags = 7'b0; e.addr = RPC; e.chk_addr = 1'b1;
    exp_q.push_back(e);
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect, busy};
      total++;
      if (act !== e.flags) begin
        bad++;
        $display("FAIL ctrl_flags @%0t: got %b required %b", $time, act, e.flags);
      end
      if (e.chk_addr) begin
        total++;
        if (redirect_addr !== e.addr) begin
          bad++;
          $display("FAIL redirect_addr @%0t: got %h required %h", $time, redirect_addr, e.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    stim_t t;
    model_reset();
    {id_valid, rs1_re, rs2_re, id_fence, ex_rd_we, ex_is_load, jump, mem_busy} = '0;
    {rs1_addr, rs2_addr, ex_rd_addr} = '0;
    id_inst_addr = '0; jump_addr = '0;
    reset_cycle();
    step(quiet());

    // Load into x5, decode reads x5 via rs2: one stall, then clear once the load moves on
    t = quiet(); t.v = 1; t.rs2 = 5'd5; t.re2 = 1; t.we = 1; t.ld = 1; t.rd = 5'd5;
    step(t);
    t.ld = 0; step(t);
    // Same with rd = x0: never a hazard
    t = quiet(); t.v = 1; t.rs2 = 5'd0; t.re2 = 1; t.we = 1; t.ld = 1; t.rd = 5'd0;
    step(t);
    // Jump beats a concurrent load-use hit
    t = quiet(); t.v = 1; t.rs1 = 5'd7; t.re1 = 1; t.we = 1; t.ld = 1; t.rd = 5'd7;
    t.jmp = 1; t.jaddr = 32'h0000_0100;
    step(t);
    // Fence at 0x40: drain then redirect to 0x44
    t = quiet(); t.v = 1; t.fence = 1; t.iaddr = 32'h0000_0040;
    step(t);
    for (int i = 0; i < 5; i++) step(quiet());
    // Memory wait in the 2nd drain cycle freezes the counter for 3 cycles
    step(t);
    step(quiet());
    t = quiet(); t.mb = 1;
    for (int i = 0; i < 3; i++) step(t);
    for (int i = 0; i < 4; i++) step(quiet());
    // Reset in the middle of a drain
    t = quiet(); t.v = 1; t.fence = 1; t.iaddr = 32'h0000_0080;
    step(t);
    step(quiet());
    reset_cycle();
    for (int i = 0; i < 3; i++) step(quiet());
    // Address wrap on fence at the top of memory
    t = quiet(); t.v = 1; t.fence = 1; t.iaddr = 32'hFFFF_FFFC;
    step(t);
    for (int i = 0; i < 4; i++) step(quiet());

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_cycle();
      end else begin
        t.v     = ($urandom_range(0, 3) != 0);
        t.rs1   = 5'($urandom_range(0, 3));
        t.rs2   = 5'($urandom_range(0, 3));
        t.re1   = 1'($urandom);
        t.re2   = 1'($urandom);
        t.fence = ($urandom_range(0, 19) == 0);
        t.iaddr = $urandom & 32'hFFFF_FFFC;
        t.we    = 1'($urandom);
        t.rd    = 5'($urandom_range(0, 3));
        t.ld    = 1'($urandom);
        t.jmp   = ($urandom_range(0, 7) == 0);
        t.jaddr = $urandom;
        t.mb    = ($urandom_range(0, 5) == 0);
        step(t);
      end
    end

    for (int i = 0; i < 12; i++) step(quiet());
    @(posedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    total++;
    if (load_stall_cnt !== 32'(m_loads) || flush_cnt !== 32'(m_jumps) || fence_cnt !== 32'(m_fences)) begin
      bad++;
      $display("FAIL perf_counters: got %0d/%0d/%0d required %0d/%0d/%0d",
               load_stall_cnt, flush_cnt, fence_cnt, m_loads, m_jumps, m_fences);
    end
`endif
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline hazard and sequencing controller for the RV32I core. It sits beside the decode stage and the fetch/decode flop. It watches decode source registers, the execute-stage destination, jump requests, memory wait and FENCE/FENCE.I, and drives stall, flush and PC-redirect controls to the fetch, decode and execute pipeline registers. All control/redirect decisions are centralised here; the datapath stages contain no hazard logic.

Parameters:
DRAIN_CYCLES, 2, cycles to hold the front end after a FENCE/FENCE.I enters execute (covers the EX to writeback depth); legal 1..7
RESET_PC, 32'h0000_0000, value driven on redirect_addr_o while idle/reset

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-low reset
id_valid_i  input  1  decode holds a valid instruction
rs1_addr_i  input  5  decode rs1 address
rs2_addr_i  input  5  decode rs2 address
rs1_re_i  input  1  decode instruction reads rs1
rs2_re_i  input  1  decode instruction reads rs2
id_fence_i  input  1  decode instruction is FENCE or FENCE.I
id_inst_addr_i  input  32  decode instruction address
ex_rd_we_i  input  1  execute instruction writes rd
ex_rd_addr_i  input  5  execute rd address
ex_is_load_i  input  1  execute instruction is a load
jump_i  input  1  execute resolved taken branch/jump
jump_addr_i  input  32  jump target
mem_busy_i  input  1  data memory not ready; whole pipe must freeze
stall_if_o  output  1  hold PC
stall_id_o  output  1  hold fetch/decode register
stall_ex_o  output  1  hold decode/execute register
flush_id_o  output  1  fetch/decode register loads NOP
flush_ex_o  output  1  decode/execute register loads NOP
redirect_o  output  1  PC loads redirect_addr_o
redirect_addr_o  output  32  new PC
busy_o  output  1  FSM not IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; drain counter 0; saved PC = RESET_PC; all 1-bit outputs 0; redirect_addr_o = RESET_PC. This also applies mid-fence: any in-progress drain is abandoned.
- Hazard evaluation is combinational from the inputs and the current state. State and counter update on the rising clk edge.
- Load-use hit: id_valid_i & ex_is_load_i & ex_rd_we_i & ex_rd_addr_i!=0 & ((rs1_re_i & rs1_addr_i==ex_rd_addr_i) | (rs2_re_i & rs2_addr_i==ex_rd_addr_i)).
- Priority when in IDLE, highest first:
  1. mem_busy_i: stall_if_o=stall_id_o=stall_ex_o=1. No flush, no redirect. State unchanged.
  2. jump_i: redirect_o=1, redirect_addr_o=jump_addr_i, flush_id_o=flush_ex_o=1. A concurrent load-use hit or id_fence_i is discarded because it is on the wrong path.
  3. id_fence_i & id_valid_i: stall_if_o=stall_id_o=1, flush_ex_o=1. Save id_inst_addr_i+4 (mod 2^32). Load counter with DRAIN_CYCLES. Go to DRAIN.
  4. load-use hit: stall_if_o=stall_id_o=1, flush_ex_o=1 for exactly one cycle. No state change; the next cycle re-evaluates with the load now past EX.
- DRAIN: stall_if_o=stall_id_o=1, flush_ex_o=1, busy_o=1. The counter decrements each cycle unless mem_busy_i is high; while mem_busy_i is high the counter freezes and stall_ex_o=1. At counter==1 with mem_busy_i=0, go to REDIR. jump_i in DRAIN is ignored because EX holds only bubbles.
- REDIR (one cycle): redirect_o=1, redirect_addr_o=saved PC, flush_id_o=flush_ex_o=1, busy_o=1. Next state IDLE. If mem_busy_i is high, stay in REDIR with the redirect held and stall_ex_o=1.
- An unused state encoding returns to IDLE.
- x0 is never a hazard source.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs load_stall_cnt_o[31:0], flush_cnt_o[31:0] and fence_cnt_o[31:0].
  - load_stall_cnt_o increments each cycle a load-use stall is issued.
  - flush_cnt_o increments on each jump redirect.
  - fence_cnt_o increments on DRAIN entry.
  - All three wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist. Functional behaviour is identical either way.

Decomposition:
- defines.v (shared) gains:
  - PIPE_CTRL state encodings (IDLE=2'd0, DRAIN=2'd1, REDIR=2'd2).
  - The NOP encoding 32'h0000_0013 used by flushed registers.
  - Existing REG_ADDR_WIDTH/INST_ADDR_WIDTH are reused.
- One sub-module, hazard_detect: the purely combinational load-use comparator. It is reused by a future forwarding unit.
- FSM, counter and output muxing remain in pipe_ctrl.

Test Plan:
- Load into x5 in EX, decode reads rs2=x5 with rs2_re=1 -> one cycle stall_if/stall_id/flush_ex=1, then all 0; with rd=x0 -> no stall.
- jump_i=1, jump_addr=0x0000_0100, simultaneous load-use hit -> redirect_o=1, addr 0x100, flush_id=flush_ex=1, stall_if=0.
- id_fence_i at id_inst_addr 0x0000_0040, DRAIN_CYCLES=2 -> stalls for 2 cycles, then REDIR with redirect_addr 0x44, then IDLE; busy_o high 3 cycles.
- mem_busy_i asserted during the 2nd DRAIN cycle for 3 cycles -> counter frozen, all three stalls high, REDIR delayed by 3 cycles.
- rst pulsed low mid-DRAIN -> all outputs 0 immediately (async), redirect_addr=RESET_PC, state IDLE after release.
- PIPE_CTRL_PERF_EN defined: 4 load-use stalls, 2 jumps, 1 fence -> counters read 4/2/1.
